// File: rtl/soc_mem_pkg.sv
// Shared types and helpers for the CV32E40P shared-memory arbiter.
// Response-source encoding, request bundle and address-window check.
package soc_mem_pkg;

    typedef enum logic [1:0] {SRC_NONE, SRC_INSTR, SRC_DATA} src_e;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    localparam logic [31:0] MEM_ARB_ERR_RDATA = 32'h0;

    // Requester bit positions on the arbiter req/gnt vectors
    localparam int unsigned REQ_INSTR = 0;
    localparam int unsigned REQ_DATA  = 1;

    // Word-granular compare avoids overflow of base + 4*words at the top of the map
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int unsigned words);
        logic [31:0] offset;
        offset = addr - base;
        return (addr >= base) && ((offset >> 2) < words);
    endfunction

endpackage

// File: rtl/cv32e_shared_mem_arbiter_if.sv
// CV32E40P instruction-fetch and LSU bus interfaces (OBI-style req/gnt/rvalid).
// The arbiter connects to both through their SLAVE modports.
interface CV32E_INST_INF;
    logic        instr_req;
    logic        instr_gnt;
    logic [31:0] instr_addr;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;

    modport MASTER (output instr_req, instr_addr,
                    input  instr_gnt, instr_rvalid, instr_rdata);
    modport SLAVE  (input  instr_req, instr_addr,
                    output instr_gnt, instr_rvalid, instr_rdata);
endinterface

interface CV32E_DATA_INF;
    logic        data_req;
    logic        data_gnt;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_rvalid;
    logic [31:0] data_rdata;

    modport MASTER (output data_req, data_we, data_be, data_addr, data_wdata,
                    input  data_gnt, data_rvalid, data_rdata);
    modport SLAVE  (input  data_req, data_we, data_be, data_addr, data_wdata,
                    output data_gnt, data_rvalid, data_rdata);
endinterface

// File: rtl/mem_arb_rr2.sv
// Two-requester arbiter (bit 0 = instr, bit 1 = data). Define CV32E_MEM_ARB_RR_EN
// for round-robin on conflicts; otherwise fixed priority with data winning.
module mem_arb_rr2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic prio_data_q;
    logic prio_data_d;
    logic conflict;

    assign conflict = &req;

    always_comb begin
        gnt = req;
        if (conflict) begin
            gnt = prio_data_q ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
`ifdef CV32E_MEM_ARB_RR_EN
        // Pointer only moves when both ports competed
        prio_data_d = conflict ? ~prio_data_q : prio_data_q;
`else
        prio_data_d = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_data_q <= 1'b1;
        end else begin
            prio_data_q <= prio_data_d;
        end
    end

endmodule

// File: rtl/cv32e_shared_mem_arbiter.sv
// Shares one 1-cycle-latency single-port SRAM between the CV32E40P fetch and LSU ports.
// Arbitration policy selected by CV32E_MEM_ARB_RR_EN (evaluated in mem_arb_rr2).
module cv32e_shared_mem_arbiter
    import soc_mem_pkg::*;
#(
    parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 8192,
    localparam int unsigned AW       = $clog2(MEM_WORDS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    CV32E_INST_INF.SLAVE        inst_if,
    CV32E_DATA_INF.SLAVE        data_if,
    output logic                mem_en_o,
    output logic                mem_we_o,
    output logic [AW-1:0]       mem_addr_o,
    output logic [3:0]          mem_be_o,
    output logic [31:0]         mem_wdata_o,
    input  logic [31:0]         mem_rdata_i
);

    logic [1:0]  req;
    logic [1:0]  gnt;
    mem_req_t    sel;
    logic        sel_in_win;
    logic [31:0] offset;
    src_e        src_q;
    logic        rd_q;
    logic [31:0] rsp_rdata;

    // Requests are masked during reset so no grant or SRAM strobe leaks out
    assign req = {data_if.data_req, inst_if.instr_req} & {2{~rst_i}};

    mem_arb_rr2 u_arb (
        .clk (clk_i),
        .rst (rst_i),
        .req (req),
        .gnt (gnt)
    );

    assign inst_if.instr_gnt = gnt[REQ_INSTR];
    assign data_if.data_gnt  = gnt[REQ_DATA];

    always_comb begin
        sel.we    = 1'b0;
        sel.be    = 4'hF;
        sel.addr  = inst_if.instr_addr;
        sel.wdata = '0;
        if (gnt[REQ_DATA]) begin
            sel.we    = data_if.data_we;
            sel.be    = data_if.data_be;
            sel.addr  = data_if.data_addr;
            sel.wdata = data_if.data_wdata;
        end
    end

    always_comb begin
        sel_in_win  = in_window(sel.addr, MEM_BASE, MEM_WORDS);
        offset      = sel.addr - MEM_BASE;
        mem_en_o    = (|gnt) & sel_in_win;
        mem_we_o    = sel.we;
        mem_addr_o  = AW'(offset >> 2);
        mem_be_o    = sel.be;
        mem_wdata_o = sel.wdata;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src_q <= SRC_NONE;
            rd_q  <= 1'b0;
        end else begin
            if (gnt[REQ_DATA]) begin
                src_q <= SRC_DATA;
            end else if (gnt[REQ_INSTR]) begin
                src_q <= SRC_INSTR;
            end else begin
                src_q <= SRC_NONE;
            end
            rd_q <= mem_en_o & ~mem_we_o;
        end
    end

    // Writes and out-of-window accesses return the fixed error word, never stale SRAM data
    assign rsp_rdata = rd_q ? mem_rdata_i : MEM_ARB_ERR_RDATA;

    always_comb begin
        inst_if.instr_rvalid = (src_q == SRC_INSTR) & ~rst_i;
        data_if.data_rvalid  = (src_q == SRC_DATA) & ~rst_i;
        inst_if.instr_rdata  = inst_if.instr_rvalid ? rsp_rdata : '0;
        data_if.data_rdata   = data_if.data_rvalid ? rsp_rdata : '0;
    end

endmodule

// File: tb/tb_cv32e_shared_mem_arbiter.sv
// Directed self-checking bench for cv32e_shared_mem_arbiter with a behavioural SRAM.
// Expectations follow CV32E_MEM_ARB_RR_EN when it is defined for the build.
module tb_cv32e_shared_mem_arbiter;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int unsigned WORDS = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_en;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] sram_rdata = '0;
    logic [31:0] sram [WORDS];

    int n_checks = 0;
    int n_fail   = 0;

    CV32E_INST_INF inst_if();
    CV32E_DATA_INF data_if();

    cv32e_shared_mem_arbiter #(
        .MEM_BASE  (BASE),
        .MEM_WORDS (WORDS)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .inst_if     (inst_if),
        .data_if     (data_if),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_be_o    (mem_be),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (sram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                sram_rdata <= sram[mem_addr];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_instr(input logic req, input logic [31:0] addr);
        inst_if.instr_req  = req;
        inst_if.instr_addr = addr;
    endtask

    task automatic set_data(input logic req, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata);
        data_if.data_req   = req;
        data_if.data_we    = we;
        data_if.data_be    = be;
        data_if.data_addr  = addr;
        data_if.data_wdata = wdata;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_instr(1'b1, 32'h100);
        set_data(1'b1, 1'b1, 4'hF, 32'h100, 32'h1234_5678);
        step();
        step();
        sample();
        n_checks++; if (inst_if.instr_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_instr_gnt got %b want 0", inst_if.instr_gnt); end
        n_checks++; if (data_if.data_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_data_gnt got %b want 0", data_if.data_gnt); end
        n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en got %b want 0", mem_en); end
        n_checks++; if (inst_if.instr_rvalid !== 1'b0 || inst_if.instr_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_instr_rsp got %b/%h want 0/0", inst_if.instr_rvalid, inst_if.instr_rdata); end
        n_checks++; if (data_if.data_rvalid !== 1'b0 || data_if.data_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_data_rsp got %b/%h want 0/0", data_if.data_rvalid, data_if.data_rdata); end
        step();
        rst = 1'b0;
        set_instr(1'b0, 32'h0);
        set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        sample();
        n_checks++; if (inst_if.instr_rvalid !== 1'b0 || data_if.data_rvalid !== 1'b0) begin n_fail++; $display("FAIL post_rst_rvalid got %b/%b want 0/0", inst_if.instr_rvalid, data_if.data_rvalid); end
        n_checks++; if (inst_if.instr_gnt !== 1'b0 || data_if.data_gnt !== 1'b0) begin n_fail++; $display("FAIL idle_gnt got %b/%b want 0/0", inst_if.instr_gnt, data_if.data_gnt); end
    endtask

    task automatic test_instr_reads();
        step(); set_data(1'b1, 1'b1, 4'hF, 32'h100, 32'hAAAA_0001);
        step(); set_data(1'b1, 1'b1, 4'hF, 32'h104, 32'hAAAA_0002);
        step(); set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step(); set_instr(1'b1, 32'h100);
        sample();
        n_checks++; if (inst_if.instr_gnt !== 1'b1 || data_if.data_gnt !== 1'b0) begin n_fail++; $display("FAIL ird_gnt got %b/%b want 1/0", inst_if.instr_gnt, data_if.data_gnt); end
        n_checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'hF) begin n_fail++; $display("FAIL ird_mem_ctl got en%b we%b be%h want en1 we0 beF", mem_en, mem_we, mem_be); end
        n_checks++; if (mem_addr !== 13'h040) begin n_fail++; $display("FAIL ird_addr0 got %h want 040", mem_addr); end
        step(); set_instr(1'b1, 32'h104);
        sample();
        n_checks++; if (inst_if.instr_rvalid !== 1'b1 || inst_if.instr_rdata !== 32'hAAAA_0001) begin n_fail++; $display("FAIL ird_rsp0 got %b/%h want 1/aaaa0001", inst_if.instr_rvalid, inst_if.instr_rdata); end
        n_checks++; if (inst_if.instr_gnt !== 1'b1 || mem_addr !== 13'h041) begin n_fail++; $display("FAIL ird_b2b_gnt got %b/%h want 1/041", inst_if.instr_gnt, mem_addr); end
        step(); set_instr(1'b0, 32'h0);
        sample();
        n_checks++; if (inst_if.instr_rvalid !== 1'b1 || inst_if.instr_rdata !== 32'hAAAA_0002) begin n_fail++; $display("FAIL ird_rsp1 got %b/%h want 1/aaaa0002", inst_if.instr_rvalid, inst_if.instr_rdata); end
        n_checks++; if (data_if.data_rvalid !== 1'b0) begin n_fail++; $display("FAIL ird_data_rvalid got %b want 0", data_if.data_rvalid); end
        step();
        sample();
        n_checks++; if (inst_if.instr_rvalid !== 1'b0) begin n_fail++; $display("FAIL ird_rvalid_once got %b want 0", inst_if.instr_rvalid); end
    endtask

    task automatic test_write_read();
        step(); set_data(1'b1, 1'b1, 4'hF, 32'h200, 32'hDEAD_BEEF);
        sample();
        n_checks++; if (data_if.data_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("FAIL wr_ctl got gnt%b en%b we%b want 1/1/1", data_if.data_gnt, mem_en, mem_we); end
        n_checks++; if (mem_addr !== 13'h080 || mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_fields got %h/%h want 080/deadbeef", mem_addr, mem_wdata); end
        step(); set_data(1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
        sample();
        n_checks++; if (data_if.data_rvalid !== 1'b1 || data_if.data_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_rsp got %b/%h want 1/0", data_if.data_rvalid, data_if.data_rdata); end
        n_checks++; if (data_if.data_gnt !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rd_ctl got gnt%b we%b want 1/0", data_if.data_gnt, mem_we); end
        step(); set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        sample();
        n_checks++; if (data_if.data_rvalid !== 1'b1 || data_if.data_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_rsp got %b/%h want 1/deadbeef", data_if.data_rvalid, data_if.data_rdata); end
    endtask

    task automatic test_partial_write();
        step(); set_data(1'b1, 1'b1, 4'hF, 32'h300, 32'h1122_3344);
        step(); set_data(1'b1, 1'b1, 4'b0010, 32'h300, 32'h0000_5500);
        sample();
        n_checks++; if (mem_be !== 4'b0010) begin n_fail++; $display("FAIL pw_be got %b want 0010", mem_be); end
        step(); set_data(1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
        step(); set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        sample();
        n_checks++; if (data_if.data_rvalid !== 1'b1 || data_if.data_rdata !== 32'h1122_5544) begin n_fail++; $display("FAIL pw_rdata got %b/%h want 1/11225544", data_if.data_rvalid, data_if.data_rdata); end
    endtask

    task automatic test_conflict();
        logic exp_d [4];
`ifdef CV32E_MEM_ARB_RR_EN
        exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        step();
        set_instr(1'b1, 32'h100);
        set_data(1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
        for (int i = 0; i < 4; i++) begin
            sample();
            n_checks++; if (data_if.data_gnt !== exp_d[i] || inst_if.instr_gnt !== !exp_d[i]) begin n_fail++; $display("FAIL conf_gnt%0d got d%b i%b want d%b", i, data_if.data_gnt, inst_if.instr_gnt, exp_d[i]); end
            if (i > 0) begin
                n_checks++;
                if (exp_d[i-1] ? (data_if.data_rvalid !== 1'b1 || data_if.data_rdata !== 32'hDEAD_BEEF)
                               : (inst_if.instr_rvalid !== 1'b1 || inst_if.instr_rdata !== 32'hAAAA_0001)) begin
                    n_fail++; $display("FAIL conf_rsp%0d got d%b/%h i%b/%h", i, data_if.data_rvalid, data_if.data_rdata, inst_if.instr_rvalid, inst_if.instr_rdata);
                end
            end
            step();
        end
        set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        sample();
        n_checks++; if (inst_if.instr_gnt !== 1'b1 || data_if.data_gnt !== 1'b0) begin n_fail++; $display("FAIL conf_release got i%b d%b want 1/0", inst_if.instr_gnt, data_if.data_gnt); end
        n_checks++;
        if (exp_d[3] ? (data_if.data_rvalid !== 1'b1 || data_if.data_rdata !== 32'hDEAD_BEEF)
                     : (inst_if.instr_rvalid !== 1'b1 || inst_if.instr_rdata !== 32'hAAAA_0001)) begin
            n_fail++; $display("FAIL conf_rsp4 got d%b/%h i%b/%h", data_if.data_rvalid, data_if.data_rdata, inst_if.instr_rvalid, inst_if.instr_rdata);
        end
        step(); set_instr(1'b0, 32'h0);
        sample();
        n_checks++; if (inst_if.instr_rvalid !== 1'b1 || inst_if.instr_rdata !== 32'hAAAA_0001) begin n_fail++; $display("FAIL conf_instr_rsp got %b/%h want 1/aaaa0001", inst_if.instr_rvalid, inst_if.instr_rdata); end
    endtask

    task automatic test_out_of_window();
        step(); set_data(1'b1, 1'b1, 4'hF, 32'h0, 32'h5A5A_5A5A);
        step(); set_data(1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
        step(); set_data(1'b1, 1'b1, 4'hF, BASE + 4 * WORDS, 32'hFFFF_FFFF);
        sample();
        n_checks++; if (data_if.data_gnt !== 1'b1 || mem_en !== 1'b0) begin n_fail++; $display("FAIL oow_wr_ctl got gnt%b en%b want 1/0", data_if.data_gnt, mem_en); end
        n_checks++; if (data_if.data_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL oow_prior_rd got %h want deadbeef", data_if.data_rdata); end
        step(); set_data(1'b1, 1'b0, 4'hF, BASE + 4 * WORDS + 32'h4, 32'h0);
        sample();
        n_checks++; if (data_if.data_rvalid !== 1'b1 || data_if.data_rdata !== 32'h0) begin n_fail++; $display("FAIL oow_wr_rsp got %b/%h want 1/0", data_if.data_rvalid, data_if.data_rdata); end
        n_checks++; if (data_if.data_gnt !== 1'b1 || mem_en !== 1'b0) begin n_fail++; $display("FAIL oow_rd_ctl got gnt%b en%b want 1/0", data_if.data_gnt, mem_en); end
        step(); set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        sample();
        n_checks++; if (data_if.data_rvalid !== 1'b1 || data_if.data_rdata !== 32'h0) begin n_fail++; $display("FAIL oow_rd_rsp got %b/%h want 1/0", data_if.data_rvalid, data_if.data_rdata); end
        n_checks++; if (sram[0] !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL oow_sram got %h want 5a5a5a5a", sram[0]); end
    endtask

    task automatic test_reset_mid();
        step(); set_instr(1'b1, 32'h100);
        sample();
        n_checks++; if (inst_if.instr_gnt !== 1'b1) begin n_fail++; $display("FAIL rm_gnt got %b want 1", inst_if.instr_gnt); end
        step(); rst = 1'b1; set_instr(1'b1, 32'h104);
        sample();
        n_checks++; if (inst_if.instr_rvalid !== 1'b0 || inst_if.instr_rdata !== 32'h0) begin n_fail++; $display("FAIL rm_dropped got %b/%h want 0/0", inst_if.instr_rvalid, inst_if.instr_rdata); end
        n_checks++; if (inst_if.instr_gnt !== 1'b0 || mem_en !== 1'b0 || data_if.data_rvalid !== 1'b0) begin n_fail++; $display("FAIL rm_outputs got gnt%b en%b drv%b want 0/0/0", inst_if.instr_gnt, mem_en, data_if.data_rvalid); end
        step(); rst = 1'b0;
        sample();
        n_checks++; if (inst_if.instr_rvalid !== 1'b0) begin n_fail++; $display("FAIL rm_no_stale got %b want 0", inst_if.instr_rvalid); end
        n_checks++; if (inst_if.instr_gnt !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 13'h041) begin n_fail++; $display("FAIL rm_regrant got gnt%b en%b addr%h want 1/1/041", inst_if.instr_gnt, mem_en, mem_addr); end
        step(); set_instr(1'b0, 32'h0);
        sample();
        n_checks++; if (inst_if.instr_rvalid !== 1'b1 || inst_if.instr_rdata !== 32'hAAAA_0002) begin n_fail++; $display("FAIL rm_rsp got %b/%h want 1/aaaa0002", inst_if.instr_rvalid, inst_if.instr_rdata); end
    endtask

    initial begin
        test_reset();
        test_instr_reads();
        test_write_read();
        test_partial_write();
        test_conflict();
        test_out_of_window();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
